bsg_mesh_proc_traffic_endpoint: RTL and testbench

- Synthesizable processor-side endpoint attached to the P port of one bsg_mesh_router tile.
- Upstream half: injects exactly one packet to every tile in the mesh, its own tile included.
- Downstream half: consumes packets the router delivers on P and checks their routing and uniqueness.
- Used for mesh bring-up and for congestion and soak tests.

---
 rtl/bsg_mesh_proc_traffic_endpoint.sv | 185 ++++++++++++++++++
 tb/tb_bsg_mesh_proc_traffic_endpoint.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mesh_proc_traffic_endpoint.sv
// Processor-side traffic endpoint for one mesh router P port.
// Injects one packet to every tile and checks what the router delivers back.
module bsg_mesh_proc_traffic_endpoint #(
    parameter int x_cord_width_p = 2,
    parameter int y_cord_width_p = 2,
    parameter int data_width_p   = 4,
    localparam int cord_w = x_cord_width_p + y_cord_width_p,
    localparam int msize  = 1 << cord_w,
    localparam int width  = data_width_p + cord_w
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      start_i,
    output logic                      v_o,
    output logic [width-1:0]          data_o,
    input  logic                      yumi_i,
    input  logic                      v_i,
    input  logic [width-1:0]          data_i,
    output logic                      ready_o,
    output logic                      tx_done_o,
    output logic                      rx_done_o,
    output logic [cord_w:0]           rx_count_o,
    output logic                      err_misroute_o,
    output logic                      err_dup_o,
    output logic                      err_extra_o
);

    typedef enum logic [1:0] {
        tx_idle = 2'b00,
        tx_send = 2'b01,
        tx_done = 2'b10
    } tx_state_e;

    tx_state_e               state_r, state_next_s;
    logic [cord_w-1:0]       count_r, count_next_s;
    logic [cord_w-1:0]       my_id_s;
    logic [data_width_p-1:0] payload_s;

    assign my_id_s = {my_y_i, my_x_i};

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= tx_idle;
            count_r <= '0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // TX next-state logic; start_i is only honoured outside SEND
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            tx_idle, tx_done: begin
                if (start_i) begin
                    state_next_s = tx_send;
                    count_next_s = '0;
                end else begin
                    state_next_s = state_r;
                end
            end
            tx_send: begin
                if (yumi_i) begin
                    count_next_s = count_r + cord_w'(1);
                    if (count_r == {cord_w{1'b1}}) begin
                        state_next_s = tx_done;
                    end else begin
                        state_next_s = tx_send;
                    end
                end else begin
                    count_next_s = count_r;
                end
            end
            default: begin
                state_next_s = tx_idle;
                count_next_s = '0;
            end
        endcase
    end

    // TX outputs; data_o is zero whenever no packet is offered
    always_comb begin
        payload_s              = '0;
        payload_s[cord_w-1:0]  = my_id_s;
        v_o                    = 1'b0;
        tx_done_o              = 1'b0;
        data_o                 = '0;
        case (state_r)
            tx_send: begin
                v_o    = 1'b1;
                data_o = {payload_s, my_id_s ^ count_r};
            end
            tx_done: tx_done_o = 1'b1;
            default: v_o = 1'b0;
        endcase
    end

    logic              restart_s;
    logic              accept_s;
    logic [cord_w-1:0] src_s;
    logic [cord_w-1:0] dest_s;
    logic [msize-1:0]  src_onehot_s;
    logic [msize-1:0]  bitmap_r, bitmap_next_s;
    logic [cord_w:0]   rx_count_r, rx_count_next_s;
    logic              rx_done_r, rx_done_next_s;
    logic              mis_r, mis_next_s;
    logic              dup_r, dup_next_s;
    logic              extra_r, extra_next_s;
    logic              done_base_s;
    logic              unused_data_s;

    assign ready_o       = 1'b1;
    assign accept_s      = v_i & ready_o;
    assign restart_s     = (state_r == tx_done) & start_i;
    assign dest_s        = data_i[cord_w-1:0];
    assign src_s         = data_i[cord_w +: cord_w];
    assign src_onehot_s  = msize'(1) << src_s;
    assign unused_data_s = ^data_i;

    // RX bookkeeping: a restart clears first, so a same-cycle packet lands in the new sweep
    always_comb begin
        bitmap_next_s   = restart_s ? '0 : bitmap_r;
        rx_count_next_s = restart_s ? '0 : rx_count_r;
        mis_next_s      = restart_s ? 1'b0 : mis_r;
        dup_next_s      = restart_s ? 1'b0 : dup_r;
        extra_next_s    = restart_s ? 1'b0 : extra_r;
        done_base_s     = restart_s ? 1'b0 : rx_done_r;
        if (accept_s) begin
            if (rx_count_next_s != {(cord_w+1){1'b1}}) begin
                rx_count_next_s = rx_count_next_s + (cord_w+1)'(1);
            end else begin
                rx_count_next_s = rx_count_next_s;
            end
            if (dest_s != my_id_s) begin
                mis_next_s = 1'b1;
            end else begin
                mis_next_s = mis_next_s;
            end
            if ((bitmap_next_s & src_onehot_s) != '0) begin
                dup_next_s = 1'b1;
            end else begin
                bitmap_next_s = bitmap_next_s | src_onehot_s;
            end
            if (done_base_s) begin
                extra_next_s = 1'b1;
            end else begin
                extra_next_s = extra_next_s;
            end
        end else begin
            bitmap_next_s = bitmap_next_s;
        end
        rx_done_next_s = &bitmap_next_s;
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_r   <= '0;
            rx_count_r <= '0;
            rx_done_r  <= 1'b0;
            mis_r      <= 1'b0;
            dup_r      <= 1'b0;
            extra_r    <= 1'b0;
        end else begin
            bitmap_r   <= bitmap_next_s;
            rx_count_r <= rx_count_next_s;
            rx_done_r  <= rx_done_next_s;
            mis_r      <= mis_next_s;
            dup_r      <= dup_next_s;
            extra_r    <= extra_next_s;
        end
    end

    assign rx_count_o     = rx_count_r;
    assign rx_done_o      = rx_done_r;
    assign err_misroute_o = mis_r;
    assign err_dup_o      = dup_r;
    assign err_extra_o    = extra_r;

endmodule

// File: tb/tb_bsg_mesh_proc_traffic_endpoint.sv
// Scoreboard bench for the traffic endpoint on a 2x2 mesh tile (my_id = 2).
module tb_bsg_mesh_proc_traffic_endpoint;
    localparam int XW = 1, YW = 1, DW = 4, CW = 2, MS = 4, W = 6;
    localparam logic [CW-1:0] MY_ID = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b1, start_i = 1'b0, yumi_i = 1'b0, v_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic v_o, ready_o, tx_done_o, rx_done_o, err_misroute_o, err_dup_o, err_extra_o;
    logic [W-1:0] data_o;
    logic [CW:0] rx_count_o;

    always #5 clk = ~clk;

    bsg_mesh_proc_traffic_endpoint #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW)
    ) dut (
        .clk(clk), .reset(reset), .my_x_i(1'b0), .my_y_i(1'b1),
        .start_i(start_i), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .tx_done_o(tx_done_o), .rx_done_o(rx_done_o), .rx_count_o(rx_count_o),
        .err_misroute_o(err_misroute_o), .err_dup_o(err_dup_o), .err_extra_o(err_extra_o)
    );

    int passed = 0, total = 0;
    logic [W-1:0] exp_q[$];
    int pushed = 0, popped = 0;
    bit tx_idle = 1'b1;
    bit seen[int];
    int m_cnt = 0;
    bit m_mis = 1'b0, m_dup = 1'b0, m_ext = 1'b0, m_done = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rx_clear;
        seen.delete();
        m_cnt = 0; m_mis = 1'b0; m_dup = 1'b0; m_ext = 1'b0; m_done = 1'b0;
    endtask

    task automatic check_rx;
        check("rx_count", 32'(rx_count_o), 32'(m_cnt));
        check("rx_done", 32'(rx_done_o), 32'(m_done));
        check("err_misroute", 32'(err_misroute_o), 32'(m_mis));
        check("err_dup", 32'(err_dup_o), 32'(m_dup));
        check("err_extra", 32'(err_extra_o), 32'(m_ext));
        check("ready", 32'(ready_o), 32'd1);
    endtask

    // One clock of stimulus: optional start pulse and optional delivered packet
    task automatic cycle(input bit st, input bit pv, input logic [CW-1:0] src, input logic [CW-1:0] dest);
        logic [DW-1:0] pay;
        bit restart;
        pay = DW'($urandom);
        pay[CW-1:0] = src;
        restart = st && !tx_idle && (popped == pushed);
        if (st && (tx_idle || popped == pushed)) begin
            tx_idle = 1'b0;
            for (int k = 0; k < MS; k++) begin
                logic [CW-1:0] kk;
                kk = CW'(k);
                exp_q.push_back({DW'(MY_ID), MY_ID ^ kk});
            end
            pushed += MS;
        end
        start_i = st; v_i = pv; data_i = {pay, dest};
        tick;
        start_i = 1'b0; v_i = 1'b0;
        if (restart) rx_clear();
        if (pv) begin
            if (m_cnt < 7) m_cnt++;
            if (dest != MY_ID) m_mis = 1'b1;
            if (seen.exists(int'(src))) m_dup = 1'b1;
            else seen[int'(src)] = 1'b1;
            if (m_done) m_ext = 1'b1;
            m_done = (seen.num() == MS);
        end
        check_rx();
    endtask

    task automatic do_reset;
        reset = 1'b1; start_i = 1'b0; v_i = 1'b0;
        exp_q.delete();
        tick; tick;
        pushed = popped; tx_idle = 1'b1;
        rx_clear();
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_data_o", 32'(data_o), 32'd0);
        check("reset_tx_done", 32'(tx_done_o), 32'd0);
        check_rx();
        reset = 1'b0;
    endtask

    task automatic wait_tx_done(input bit rand_yumi);
        int n;
        n = 0;
        while (!tx_done_o && n < 200) begin
            if (rand_yumi) yumi_i = 1'($urandom);
            tick;
            n++;
        end
        check("tx_done_timeout", 32'(tx_done_o), 32'd1);
        check("tx_all_consumed", 32'(popped), 32'(pushed));
    endtask

    // Scoreboard monitor: every offered packet must match the queue head, held or consumed
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && v_o) begin
                if (exp_q.size() == 0) begin
                    check("v_o_unexpected", 32'(v_o), 32'd0);
                end else begin
                    check(yumi_i ? "tx_data" : "tx_hold", 32'(data_o), 32'(exp_q[0]));
                    if (yumi_i) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // Sweep with yumi tied high: v_o in cycles 1-4, tx_done in cycle 5
        yumi_i = 1'b1;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            check("sweep_v_o", 32'(v_o), 32'd1);
            check("sweep_not_done", 32'(tx_done_o), 32'd0);
            tick;
        end
        check("sweep_done", 32'(tx_done_o), 32'd1);
        check("sweep_v_o_low", 32'(v_o), 32'd0);

        // Alternating backpressure: 4 transfers over 8 cycles
        yumi_i = 1'b0;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            check("bp_not_done", 32'(tx_done_o), 32'd0);
            yumi_i = 1'(i % 2);
            tick;
        end
        check("bp_done", 32'(tx_done_o), 32'd1);
        check("bp_transfers", 32'(popped), 32'(pushed));

        // Random backpressure sweep
        yumi_i = 1'b0;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        wait_tx_done(1'b1);

        // Reset mid-SEND abandons the packet
        yumi_i = 1'b1;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        tick;
        yumi_i = 1'b0;
        do_reset();
        check("midsend_v_o", 32'(v_o), 32'd0);

        // Receive sweep with sources 0,3,1,2
        cycle(1'b0, 1'b1, 2'd0, MY_ID);
        cycle(1'b0, 1'b1, 2'd3, MY_ID);
        cycle(1'b0, 1'b1, 2'd1, MY_ID);
        cycle(1'b0, 1'b1, 2'd2, MY_ID);
        check("rx_sweep_done", 32'(rx_done_o), 32'd1);
        check("rx_sweep_count", 32'(rx_count_o), 32'd4);

        // Duplicate, misroute, extra and count saturation
        do_reset();
        cycle(1'b0, 1'b1, 2'd1, MY_ID);
        cycle(1'b0, 1'b1, 2'd1, MY_ID);
        cycle(1'b0, 1'b1, 2'd0, 2'd1);
        cycle(1'b0, 1'b1, 2'd2, MY_ID);
        cycle(1'b0, 1'b1, 2'd3, MY_ID);
        cycle(1'b0, 1'b0, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, 2'd0, MY_ID);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'(i), MY_ID);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 2'd0);
        check("errs_sticky", 32'({err_dup_o, err_misroute_o, err_extra_o}), 32'd7);
        check("count_saturated", 32'(rx_count_o), 32'd7);

        // First start from IDLE keeps RX state; then restart in DONE with a src-3 packet
        yumi_i = 1'b1;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        check("first_start_keeps_rx", 32'(rx_count_o), 32'd7);
        wait_tx_done(1'b0);
        yumi_i = 1'b0;
        cycle(1'b1, 1'b1, 2'd3, MY_ID);
        check("restart_count", 32'(rx_count_o), 32'd1);
        check("restart_errs", 32'({err_dup_o, err_misroute_o, err_extra_o}), 32'd0);
        cycle(1'b0, 1'b1, 2'd0, MY_ID);
        cycle(1'b0, 1'b1, 2'd1, MY_ID);
        cycle(1'b0, 1'b1, 2'd2, MY_ID);
        check("restart_bitmap_full", 32'(rx_done_o), 32'd1);
        check("restart_no_dup", 32'(err_dup_o), 32'd0);
        yumi_i = 1'b1;
        wait_tx_done(1'b0);

        // Random soak against the reference model
        for (int i = 0; i < 300; i++) begin
            yumi_i = 1'($urandom);
            cycle(($urandom % 16) == 0, 1'($urandom), 2'($urandom), ($urandom % 4 == 0) ? 2'($urandom) : MY_ID);
        end
        yumi_i = 1'b1;
        wait_tx_done(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
